// File: rtl/stage1_fetch.sv
// Instruction fetch stage: on-chip instruction memory loaded in programming mode,
// PC register and registered IF/ID instruction output for run mode.
module stage1_fetch #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Instruction_addr,
  input  logic [DATA_W-1:0] Instruction_Data,
  input  logic              ProgMode,
  input  logic              PC_sel,
  input  logic [ADDR_W-1:0] addr_BR_JMP,
  input  logic              En_Pipeline,
  output logic [DATA_W-1:0] Instruction_out
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              mem_we;

  // Memory has no reset so programmed contents survive a reset pulse; writes are
  // also blocked while reset is held low.
  assign mem_we = ~ProgMode & reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[Instruction_addr] <= Instruction_Data;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (!ProgMode) begin
      pc_d    = '0;
      instr_d = '0;
    end else if (En_Pipeline) begin
      instr_d = mem[pc_q];
      pc_d    = PC_sel ? addr_BR_JMP : pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign Instruction_out = instr_q;

endmodule

// File: tb/tb_stage1_fetch.sv
// Bench for stage1_fetch: directed program/fetch/stall/branch/reset/wrap steps followed by
// randomized traffic, all checked against a simple fetch-stage model.
module tb_stage1_fetch;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] Instruction_addr = '0;
  logic [DW-1:0] Instruction_Data = '0;
  logic          ProgMode = 1'b0;
  logic          PC_sel = 1'b0;
  logic [AW-1:0] addr_BR_JMP = '0;
  logic          En_Pipeline = 1'b0;
  logic [DW-1:0] Instruction_out;

  stage1_fetch #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Instruction_addr(Instruction_addr),
    .Instruction_Data(Instruction_Data),
    .ProgMode        (ProgMode),
    .PC_sel          (PC_sel),
    .addr_BR_JMP     (addr_BR_JMP),
    .En_Pipeline     (En_Pipeline),
    .Instruction_out (Instruction_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_pc;
  logic [DW-1:0] m_out;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] exp);
    checks++;
    assert (Instruction_out === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, Instruction_out, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset) return;
    if (!ProgMode) begin
      m_mem[Instruction_addr] = Instruction_Data;
      m_pc  = 0;
      m_out = '0;
    end else if (En_Pipeline) begin
      m_out = m_mem[m_pc];
      m_pc  = PC_sel ? int'(addr_BR_JMP) : (m_pc + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset_pulse();
    #1 reset = 1'b0;
    m_pc  = 0;
    m_out = '0;
    #1 check("async_rst_low", '0);
    #1 reset = 1'b1;
  endtask

  initial begin
    m_pc  = 0;
    m_out = '0;

    // Power-on reset
    #1 reset = 1'b0;
    #1 check("reset_state", '0);
    tick();
    check("reset_held_edge", '0);
    #2 reset = 1'b1;

    // Fill entire memory with random words, then the known program at 0..3
    ProgMode = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      Instruction_addr = AW'(a);
      Instruction_Data = $urandom();
      tick();
      if (a % 512 == 0) check("prog_fill_out", '0);
    end
    begin
      logic [DW-1:0] prog [4];
      prog[0] = 32'h00221804;
      prog[1] = 32'h10220005;
      prog[2] = 32'hFC00003D;
      prog[3] = 32'h04320003;
      for (int a = 0; a < 4; a++) begin
        Instruction_addr = AW'(a);
        Instruction_Data = prog[a];
        PC_sel      = 1'b1;
        En_Pipeline = 1'b1;
        tick();
        check("prog_out_zero", '0);
      end
    end

    // Stall right after programming, then sequential fetch
    ProgMode    = 1'b1;
    En_Pipeline = 1'b0;
    PC_sel      = 1'b0;
    tick(); check("stall0", '0);
    PC_sel = 1'b1; addr_BR_JMP = 12'h7;
    tick(); check("stall_sel_ignored", '0);
    PC_sel      = 1'b0;
    En_Pipeline = 1'b1;
    tick(); check("seq_addr0", 32'h00221804);
    tick(); check("seq_addr1", 32'h10220005);
    tick(); check("seq_addr2", 32'hFC00003D);
    tick(); check("seq_addr3", 32'h04320003);
    En_Pipeline = 1'b0;
    tick(); check("hold_addr3", 32'h04320003);

    // Branch: restart via programming mode (rewrite addr0 with same word)
    ProgMode = 1'b0; Instruction_addr = '0; Instruction_Data = 32'h00221804;
    tick(); check("prog_restart", '0);
    ProgMode = 1'b1; En_Pipeline = 1'b1;
    tick(); check("br_pre0", 32'h00221804);
    tick(); check("br_pre1", 32'h10220005);
    PC_sel = 1'b1; addr_BR_JMP = '0;
    tick(); check("br_edge_old_pc", 32'hFC00003D);
    PC_sel = 1'b0;
    tick(); check("br_target", 32'h00221804);

    // Async reset mid-run, held across an enabled edge, released between edges
    #2 reset = 1'b0;
    m_pc = 0; m_out = '0;
    #1 check("async_rst_immediate", '0);
    tick(); check("async_rst_held", '0);
    #3 reset = 1'b1;
    tick(); check("post_rst_addr0", 32'h00221804);
    tick(); check("post_rst_addr1", 32'h10220005);

    // Wrap: branch to max address, then PC+1 wraps to 0
    PC_sel = 1'b1; addr_BR_JMP = '1;
    tick(); check("wrap_br_edge", m_out);
    PC_sel = 1'b0;
    tick(); check("wrap_max_addr", m_mem[DEPTH-1]);
    tick(); check("wrap_to_zero", 32'h00221804);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ProgMode         = ($urandom_range(0, 9) != 0);
      En_Pipeline      = ($urandom_range(0, 3) != 0);
      PC_sel           = ($urandom_range(0, 4) == 0);
      addr_BR_JMP      = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 7))
                                                     : AW'($urandom());
      Instruction_addr = AW'($urandom());
      Instruction_Data = $urandom();
      tick();
      check("rand_out", m_out);
      if ($urandom_range(0, 29) == 0) async_reset_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stage1_fetch.md
STAGE1_FETCH -- requirements
Module: stage1

Interface
REQ-001 Parameter: ADDR_W, default 12, instruction-memory address and PC width (memory depth 2^ADDR_W words).
REQ-002 Parameter: DATA_W, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Instruction_addr  input  ADDR_W  memory write address used in programming mode.
REQ-006 Instruction_Data  input  DATA_W  memory write data used in programming mode.
REQ-007 ProgMode  input  1  0 = programming mode (memory load), 1 = run mode (fetch).
REQ-008 PC_sel  input  1  next-PC select: 0 = PC+1, 1 = addr_BR_JMP.
REQ-009 addr_BR_JMP  input  ADDR_W  branch/jump target address.
REQ-010 En_Pipeline  input  1  fetch enable / pipeline advance in run mode.
REQ-011 Instruction_out  output  DATA_W  registered fetched instruction (IF/ID register).

Function
REQ-012 Block SHALL contain a 2^ADDR_W x DATA_W instruction memory, an ADDR_W-bit PC register and a DATA_W-bit output register.
REQ-013 ProgMode=0, rising edge: mem[Instruction_addr] <= Instruction_Data; PC <= 0; Instruction_out <= 0; En_Pipeline and PC_sel ignored.
REQ-014 ProgMode=1: memory SHALL NOT be written.
REQ-015 ProgMode=1, En_Pipeline=1, rising edge: Instruction_out <= mem[PC]; PC <= (PC_sel ? addr_BR_JMP : PC+1).
REQ-016 ProgMode=1, En_Pipeline=0: PC and Instruction_out SHALL hold.
REQ-017 Read latency: instruction at current PC appears on Instruction_out one edge after an enabled edge.
REQ-018 PC+1 SHALL wrap modulo 2^ADDR_W (max address -> 0).
REQ-019 Branch: PC_sel sampled on the enabled edge; that edge still outputs mem[old PC]; target's instruction appears on the following enabled edge.
REQ-020 PC_sel=1 with En_Pipeline=0: no effect (PC holds).
REQ-021 ProgMode 0->1 transition: first enabled edge SHALL fetch address 0.
REQ-022 Instruction_out SHALL be purely registered (no combinational path from inputs).

Reset
REQ-023 reset=0 SHALL immediately, independent of clk, force PC=0 and Instruction_out=0.
REQ-024 Memory contents SHALL NOT be altered by reset.
REQ-025 While reset=0 no memory write or PC update occurs; normal operation resumes on the first rising edge after reset returns to 1.
REQ-026 Reset asserted mid-run SHALL restart fetch from address 0 after release, with previously programmed contents intact.

Verification
REQ-027 Program: ProgMode=0, write addr0..3 = 00221804, 10220005, FC00003D, 04320003 on successive edges -> Instruction_out stays 00000000.
REQ-028 Sequential fetch: after REQ-027, ProgMode=1, En_Pipeline=1, PC_sel=0 -> Instruction_out = 00221804, 10220005, FC00003D, 04320003 on consecutive edges.
REQ-029 Stall: ProgMode=1, En_Pipeline=0 -> Instruction_out held at 00000000 and PC held at 0; enabling then yields 00221804 on the first edge.
REQ-030 Branch: while outputting addr1 data, PC_sel=1, addr_BR_JMP=0 on enabled edge -> next outputs FC00003D (addr2), then 00221804 (addr0).
REQ-031 Async reset: assert reset=0 between edges during run -> Instruction_out=00000000 immediately; after release, next enabled edge outputs 00221804.
REQ-032 Wrap: addr_BR_JMP=all-ones, PC_sel=1, then PC_sel=0 -> fetch mem[max address], then mem[0].
